// File: rtl/present16_pkg.sv
// rtl/present16_pkg.sv - shared widths, state encoding, S-box table and bit permutation for the 16-bit PRESENT-style cipher
package present16_pkg;

  localparam int BLOCK_W = 16;
  localparam int KEY_W   = 32;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  // Entry x lives at bits [4x+3:4x]: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2 for x = 0..F.
  localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

  function automatic int p_index(int i);
    return (i == 15) ? 15 : (4 * i) % 15;
  endfunction

endpackage

// File: rtl/sbox.sv
// rtl/sbox.sv - single 4-bit forward S-box lookup
module sbox
  import present16_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y
);

  assign y = SBOX_TABLE[{x, 2'b00} +: 4];

endmodule

// File: rtl/sbox_layer.sv
// rtl/sbox_layer.sv - forward 16-bit S-box layer, four nibble S-boxes in parallel
module sbox_layer
  import present16_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_nib
    sbox u_sbox (
      .x (din[4*n +: 4]),
      .y (dout[4*n +: 4])
    );
  end

endmodule

// File: rtl/present16_encrypt_iter.sv
// rtl/present16_encrypt_iter.sv - iterative one-round-per-clock PRESENT-style encryption with start/done handshake
module present16_encrypt_iter
  import present16_pkg::*;
#(
  parameter int ROUNDS = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] pt_in,
  input  logic [KEY_W-1:0]   key_in,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W-1:0] ct_out
);

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  state_t             state_q;
  logic [BLOCK_W-1:0] s_q;
  logic [KEY_W-1:0]   k_q;
  logic [4:0]         r_q;

  logic [BLOCK_W-1:0] sb_in;
  logic [BLOCK_W-1:0] sb_out;
  logic [BLOCK_W-1:0] p_out;
  logic [KEY_W-1:0]   k_rot;
  logic [3:0]         k_nib;
  logic [KEY_W-1:0]   k_next;

  assign sb_in = s_q ^ k_q[31:16];

  sbox_layer u_layer (
    .din  (sb_in),
    .dout (sb_out)
  );

  for (genvar i = 0; i < BLOCK_W; i++) begin : g_perm
    assign p_out[p_index(i)] = sb_out[i];
  end

  // Rotate first, then substitute the new top nibble, then mix in the round index.
  assign k_rot = {k_q[24:0], k_q[31:25]};

  sbox u_key_sbox (
    .x (k_rot[31:28]),
    .y (k_nib)
  );

  assign k_next = {k_nib, k_rot[27:12], k_rot[11:7] ^ r_q, k_rot[6:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ct_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            s_q     <= pt_in;
            k_q     <= key_in;
            r_q     <= 5'd1;
            busy    <= 1'b1;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          s_q <= p_out;
          k_q <= k_next;
          if (r_q == LAST_ROUND) state_q <= FINAL;
          else                   r_q     <= r_q + 5'd1;
        end
        FINAL: begin
          ct_out  <= s_q ^ k_q[31:16];
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
